// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module   : counter_pkg
// Brief    : Direction constants and default parameter values for updown_counter_n.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    localparam int DEF_WIDTH     = 4;
    localparam int DEF_MODULUS   = 16;
    localparam int DEF_DB_CYCLES = 1000000;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/btn_step.sv
//------------------------------------------------------------------------------
// Module   : btn_step
// Brief    : Button synchroniser, optional debounce (DEBOUNCE_EN) and rising-edge
//            detector producing a registered one-cycle step pulse.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module btn_step
    import counter_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic cp,
    input  logic rst_n,
    input  logic i_btn,
    output logic o_step
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;
    logic r_step;
    logic w_clean;

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef DEBOUNCE_EN
    localparam int              c_DBW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [c_DBW-1:0] c_DB_LAST = c_DBW'(DB_CYCLES - 1);
    localparam logic [c_DBW-1:0] c_DB_ONE  = c_DBW'(1);

    logic [c_DBW-1:0] r_db_cnt;
    logic             r_db_state;

    // Accept a new level only after DB_CYCLES consecutive samples that differ
    // from the currently accepted one; any agreeing sample restarts the count.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_db_cnt   <= '0;
            r_db_state <= 1'b0;
        end else if (r_sync2 == r_db_state) begin
            r_db_cnt <= '0;
        end else if (r_db_cnt == c_DB_LAST) begin
            r_db_state <= r_sync2;
            r_db_cnt   <= '0;
        end else begin
            r_db_cnt <= r_db_cnt + c_DB_ONE;
        end
    end

    assign w_clean = r_db_state;
`else
    assign w_clean = r_sync2;
`endif

    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
            r_step <= 1'b0;
        end else begin
            r_prev <= w_clean;
            r_step <= w_clean & ~r_prev;
        end
    end

    assign o_step = r_step;

endmodule : btn_step

`default_nettype wire

// File: rtl/updown_counter_n.sv
//------------------------------------------------------------------------------
// Module   : updown_counter_n
// Brief    : Button-stepped modulo-N up/down counter with load and terminal-count
//            pulse; define DEBOUNCE_EN to add button debouncing.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module updown_counter_n
    import counter_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MODULUS   = DEF_MODULUS,
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic             cp,
    input  logic             rst_n,
    input  logic             btn_1,
    input  logic             dir,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    localparam logic [WIDTH-1:0] c_MAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   c_MOD = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] c_ONE = WIDTH'(1);

    logic             w_step;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] r_count;
    logic             r_tc;

`ifdef DEBOUNCE_EN
    btn_step #(
        .DB_CYCLES (DB_CYCLES)
    ) u_btn_step (
        .cp     (cp),
        .rst_n  (rst_n),
        .i_btn  (btn_1),
        .o_step (w_step)
    );
`else
    btn_step u_btn_step (
        .cp     (cp),
        .rst_n  (rst_n),
        .i_btn  (btn_1),
        .o_step (w_step)
    );
`endif

    assign w_load_val = ({1'b0, load_val} >= c_MOD) ? c_MAX : load_val;

    // Load wins over a coincident step; that step is simply lost.
    always_ff @(posedge cp or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else begin
            r_tc <= 1'b0;
            if (load) begin
                r_count <= w_load_val;
            end else if (w_step && en) begin
                unique case (dir)
                    DIR_UP: begin
                        if (r_count == c_MAX) begin
                            r_count <= '0;
                            r_tc    <= 1'b1;
                        end else begin
                            r_count <= r_count + c_ONE;
                        end
                    end
                    DIR_DOWN: begin
                        if (r_count == '0) begin
                            r_count <= c_MAX;
                            r_tc    <= 1'b1;
                        end else begin
                            r_count <= r_count - c_ONE;
                        end
                    end
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    assign count = r_count;
    assign tc    = r_tc;

endmodule : updown_counter_n

`default_nettype wire

// File: tb/tb_updown_counter_n.sv
//------------------------------------------------------------------------------
// Module   : tb_updown_counter_n
// Brief    : Self-checking bench for updown_counter_n (WIDTH=4, MODULUS=10).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_updown_counter_n;
    import counter_pkg::*;

`ifdef DEBOUNCE_EN
    localparam int c_DB = 8;
`else
    localparam int c_DB = 0;
`endif
    localparam int c_LAT    = 4 + c_DB;
    localparam int c_HOLD   = 2 + c_DB;
    localparam int c_SETTLE = 5 + c_DB;

    logic       cp       = 1'b0;
    logic       rst_n    = 1'b1;
    logic       btn_1    = 1'b0;
    logic       dir      = DIR_UP;
    logic       en       = 1'b1;
    logic       load     = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic       tc;

    updown_counter_n #(
        .WIDTH     (4),
        .MODULUS   (10),
        .DB_CYCLES (8)
    ) dut (
        .cp       (cp),
        .rst_n    (rst_n),
        .btn_1    (btn_1),
        .dir      (dir),
        .en       (en),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc)
    );

    always #5 cp = ~cp;

    int cyc = 0;
    always @(posedge cp) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        logic [3:0] cnt;
        logic       tc;
        string      name;
    } exp_t;

    typedef struct {
        bit         ld;
        bit         d;
        bit         e;
        logic [3:0] lv;
        logic [3:0] exp;
        bit         exp_tc;
    } vec_t;

    exp_t       sb[$];
    int         n_cmp = 0;
    int         n_err = 0;
    logic [3:0] prev_count = 4'd0;

    task automatic push(input int c, input logic [3:0] v, input logic t, input string nm);
        exp_t e;
        e.cyc  = c;
        e.cnt  = v;
        e.tc   = t;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input logic [3:0] got, input logic [3:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    // Any change of count or any tc pulse is a DUT output event to be matched.
    always @(negedge cp) begin
        exp_t e;
        if (count !== prev_count || tc !== 1'b0) begin
            n_cmp++;
            if (sb.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_event: got count=%0d tc=%0b at cycle %0d, want no change",
                         count, tc, cyc);
            end else begin
                e = sb.pop_front();
                if (count !== e.cnt || tc !== e.tc || (e.cyc >= 0 && cyc != e.cyc)) begin
                    n_err++;
                    $display("FAIL %s: got count=%0d tc=%0b cycle=%0d, want count=%0d tc=%0b cycle=%0d",
                             e.name, count, tc, cyc, e.cnt, e.tc, e.cyc);
                end
            end
        end
        prev_count = count;
    end

    initial begin
        vec_t       vecs[$];
        logic [3:0] cur;

        for (int i = 1; i <= 12; i++)
            vecs.push_back('{1'b0, DIR_UP, 1'b1, 4'd0, 4'(i % 10), (i == 10)});
        vecs.push_back('{1'b1, DIR_UP,   1'b1, 4'd0,  4'd0, 1'b0});
        vecs.push_back('{1'b0, DIR_DOWN, 1'b1, 4'd0,  4'd9, 1'b1});
        vecs.push_back('{1'b0, DIR_DOWN, 1'b1, 4'd0,  4'd8, 1'b0});
        vecs.push_back('{1'b1, DIR_UP,   1'b1, 4'd5,  4'd5, 1'b0});
        vecs.push_back('{1'b1, DIR_UP,   1'b1, 4'd12, 4'd9, 1'b0});
        for (int i = 0; i < 5; i++)
            vecs.push_back('{1'b0, DIR_UP, 1'b0, 4'd0, 4'd9, 1'b0});
        vecs.push_back('{1'b0, DIR_DOWN, 1'b0, 4'd0,  4'd9, 1'b0});
        vecs.push_back('{1'b0, DIR_UP,   1'b1, 4'd0,  4'd0, 1'b1});
        vecs.push_back('{1'b1, DIR_UP,   1'b1, 4'd15, 4'd9, 1'b0});

        #2 rst_n = 1'b0;
        #1;
        check("reset_count", count, 4'd0);
        check("reset_tc", {3'b0, tc}, 4'd0);
        repeat (2) @(negedge cp);
        rst_n = 1'b1;
        @(negedge cp);
        check("post_reset_count", count, 4'd0);
        cur = 4'd0;

        foreach (vecs[i]) begin
            @(negedge cp);
            dir = vecs[i].d;
            en  = vecs[i].e;
            if (vecs[i].exp != cur || vecs[i].exp_tc)
                push(cyc + (vecs[i].ld ? 1 : c_LAT), vecs[i].exp, vecs[i].exp_tc,
                     $sformatf("vec%0d", i));
            if (vecs[i].ld) begin
                load     = 1'b1;
                load_val = vecs[i].lv;
                @(negedge cp);
                load = 1'b0;
                repeat (2) @(negedge cp);
            end else begin
                btn_1 = 1'b1;
                repeat (c_HOLD) @(negedge cp);
                btn_1 = 1'b0;
                repeat (c_SETTLE) @(negedge cp);
            end
            check($sformatf("vec%0d_count", i), count, vecs[i].exp);
            cur = vecs[i].exp;
        end

        // Load lands in the same cycle as the step pulse: step must vanish.
        dir = DIR_UP;
        en  = 1'b1;
        @(negedge cp);
        push(cyc + c_LAT, 4'd3, 1'b0, "load_vs_step");
        btn_1 = 1'b1;
        repeat (c_LAT - 1) @(negedge cp);
        load     = 1'b1;
        load_val = 4'd3;
        @(negedge cp);
        load = 1'b0;
        repeat (c_HOLD) @(negedge cp);
        btn_1 = 1'b0;
        repeat (c_SETTLE + 5) @(negedge cp);
        check("load_vs_step_count", count, 4'd3);

        @(negedge cp);
        push(cyc + c_LAT, 4'd4, 1'b0, "hold100");
        btn_1 = 1'b1;
        repeat (100) @(negedge cp);
        btn_1 = 1'b0;
        repeat (c_SETTLE) @(negedge cp);
        check("hold100_count", count, 4'd4);

`ifdef DEBOUNCE_EN
        @(negedge cp);
        btn_1 = 1'b1;
        repeat (5) @(negedge cp);
        btn_1 = 1'b0;
        repeat (20) @(negedge cp);
        check("glitch_count", count, 4'd4);

        @(negedge cp);
        push(cyc + c_LAT, 4'd5, 1'b0, "db_press20");
        btn_1 = 1'b1;
        repeat (20) @(negedge cp);
        btn_1 = 1'b0;
        repeat (c_SETTLE) @(negedge cp);
        check("db_press20_count", count, 4'd5);
`endif

        @(negedge cp);
        push(cyc + 1, 4'd7, 1'b0, "load7");
        load     = 1'b1;
        load_val = 4'd7;
        @(negedge cp);
        load = 1'b0;
        @(negedge cp);
        push(-1, 4'd0, 1'b0, "async_reset");
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_count", count, 4'd0);
        check("async_reset_tc", {3'b0, tc}, 4'd0);
        btn_1 = 1'b1;
        repeat (3) @(negedge cp);
        push(cyc + c_LAT, 4'd1, 1'b0, "btn_across_reset");
        rst_n = 1'b1;
        repeat (c_HOLD + 10) @(negedge cp);
        btn_1 = 1'b0;
        repeat (c_SETTLE) @(negedge cp);
        check("btn_across_reset_count", count, 4'd1);

        // Reset while a step is still in the synchroniser pipeline.
        @(negedge cp);
        push(-1, 4'd0, 1'b0, "reset_drops_step");
        btn_1 = 1'b1;
        repeat (2 + c_DB) @(negedge cp);
        #2 rst_n = 1'b0;
        btn_1 = 1'b0;
        repeat (2) @(negedge cp);
        rst_n = 1'b1;
        repeat (c_SETTLE + 5) @(negedge cp);
        check("reset_drops_step_count", count, 4'd0);

        repeat (5) @(negedge cp);
        while (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no event, want count=%0d tc=%0b", e.name, e.cnt, e.tc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_updown_counter_n

`default_nettype wire

// File: doc/updown_counter_n.md
UPDOWN_COUNTER_N -- requirements
Module: updown_counter_n

Interface
- REQ-001 WIDTH SHALL default to 4: counter bit width, legal range 1..16.
- REQ-002 MODULUS SHALL default to 16: count range 0..MODULUS-1, legal range 2..2**WIDTH.
- REQ-003 DB_CYCLES SHALL default to 1000000: debounce stable-time in cp cycles, used only with DEBOUNCE_EN.
- REQ-004 cp  input  1  single system clock; all state SHALL change on its rising edge.
- REQ-005 rst_n  input  1  asynchronous active-low reset.
- REQ-006 btn_1  input  1  raw asynchronous push-button step request; rising edge = one step.
- REQ-007 dir  input  1  0 = count up, 1 = count down.
- REQ-008 en  input  1  step enable; steps are dropped while 0.
- REQ-009 load  input  1  synchronous load strobe, level-sampled each cycle.
- REQ-010 load_val  input  WIDTH  value applied on load.
- REQ-011 count  output  WIDTH  current count, registered.
- REQ-012 tc  output  1  terminal-count pulse, one cycle wide, registered.

Function
- REQ-013 btn_1 SHALL pass through a 2-flop synchroniser; a rising edge of the synchronised signal SHALL produce a one-cycle step pulse.
- REQ-014 Without debounce, count SHALL update on the 3rd cp rising edge after the first edge at which btn_1 is sampled high.
- REQ-015 Up step: count+1; at count==MODULUS-1 it SHALL wrap to 0 with tc=1 for that one cycle.
- REQ-016 Down step: count-1; at count==0 it SHALL wrap to MODULUS-1 with tc=1 for that one cycle.
- REQ-017 dir and en SHALL be sampled in the cycle the step pulse is present; changes at other times have no effect.
- REQ-018 load=1 SHALL set count to load_val, or to MODULUS-1 if load_val>=MODULUS, with tc=0.
- REQ-019 load SHALL take priority over a simultaneous step; that step SHALL be discarded, not deferred.
- REQ-020 Holding btn_1 high SHALL produce exactly one step; the next step requires a release then a press.
- REQ-021 tc SHALL be 0 in every cycle without a wrap step.
- REQ-022 With MODULUS==2**WIDTH, wrap SHALL equal natural binary overflow/underflow.

Reset
- REQ-023 rst_n=0 SHALL immediately force count=0, tc=0, synchroniser/edge flops=0, debounce counter=0.
- REQ-024 Reset asserted mid-debounce or mid-step SHALL drop the pending step.
- REQ-025 btn_1 held high across reset release SHALL yield exactly one step.

Configuration
- REQ-026 With DEBOUNCE_EN defined, the synchronised button SHALL be accepted only after DB_CYCLES consecutive equal samples; step latency = REQ-014 + DB_CYCLES cycles, and glitches shorter than DB_CYCLES SHALL produce no step.
- REQ-027 Without DEBOUNCE_EN, no debounce logic SHALL be present, DB_CYCLES SHALL be ignored, and REQ-014 latency applies.

Structure
- REQ-028 Package counter_pkg SHALL hold the direction constants (DIR_UP=0, DIR_DOWN=1) and the default values of WIDTH, MODULUS and DB_CYCLES.
- REQ-029 Sub-module btn_step SHALL contain the synchroniser, optional debounce and edge detector, and output the step pulse.

Verification (WIDTH=4, MODULUS=10, DEBOUNCE_EN off unless stated)
- REQ-030 Reset, then 12 up presses -> count 1..9,0,1,2; tc pulses once, at the 9->0 step.
- REQ-031 Count 0, dir=1, one press -> count=9, tc=1 for one cycle.
- REQ-032 load=1, load_val=12 -> count=9; load=1 in the same cycle as a step pulse, load_val=3 -> count=3, tc=0, no later step.
- REQ-033 en=0, 5 presses -> count unchanged; btn_1 held high for 100 cycles -> exactly one step.
- REQ-034 DEBOUNCE_EN, DB_CYCLES=8: a 5-cycle pulse -> no step; a 20-cycle press -> one step, count changes 11 cycles after btn_1 rises.
- REQ-035 rst_n asserted asynchronously mid-cycle at count=7 -> count=0 immediately; btn_1 held through release -> one step, count=1.
